// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction prefetch queue in front of the IF stage.
// Fetches words over a single-outstanding-request bus into a DEPTH-entry FIFO of
// {addr, data} pairs and answers the IF stage PC with a same-cycle hit/data.
// Branch redirects and PC mismatches (resync) flush the queue and restart fetch.
// Optional feature macro: IFQ_BYPASS_EN forwards bus_rdata to the IF stage in the
// ack cycle when the queue is empty and the returning word is the one requested.
//
// Bus handshake: bus_req/bus_addr are registered; once bus_req=1 both hold until
// the cycle bus_ack=1, bus_rdata is valid only in that cycle, and at most one
// request is outstanding. Requests are never withdrawn; a flushed request is
// tracked in DROP so its data is discarded when it returns.
module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  input  logic        inst_pop,
  output logic        inst_hit,
  output logic [31:0] inst_data,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;

  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] issue_pc, bus_addr_next, stream_pc;
  logic        bus_req_next;
  logic        hit_q, bypass, resync, flush, push, pop;

  // IF-side lookup, stream tracking, flush detection and queue occupancy
  always_comb begin
    hit_q = inst_ren && (count != '0) && (q_addr[head] == inst_addr);
`ifdef IFQ_BYPASS_EN
    bypass = (count == '0) && (state == WAIT) && bus_ack && inst_ren &&
             (bus_addr == inst_addr) && !redirect;
`else
    bypass = 1'b0;
`endif
    // Address of the next word the IF stage will see from this block
    if (count != '0)
      stream_pc = q_addr[head];
    else if (state == WAIT)
      stream_pc = bus_addr;
    else
      stream_pc = fetch_pc;

    resync = inst_ren && !redirect && (stream_pc != inst_addr);
    flush  = redirect || resync;
    pop    = hit_q && inst_pop && !flush;
    // A bypassed word that is also popped was consumed on the fly
    push   = bus_ack && (state == WAIT) && !flush && !(bypass && inst_pop);

    if (flush)
      count_next = '0;
    else
      count_next = count + CW'(push) - CW'(pop);

    inst_hit  = hit_q || bypass;
    inst_data = '0;
    if (hit_q)
      inst_data = q_data[head];
    else if (bypass)
      inst_data = bus_rdata;
  end

  // Fetch FSM next-state: issue when idle or on the ack cycle if room remains
  always_comb begin
    state_next    = state;
    bus_req_next  = bus_req;
    bus_addr_next = bus_addr;
    if (redirect)
      issue_pc = redirect_addr;
    else if (resync)
      issue_pc = inst_addr;
    else
      issue_pc = fetch_pc;
    fetch_pc_next = issue_pc;

    if (state == IDLE || bus_ack) begin
      if (count_next < FULL) begin
        state_next    = WAIT;
        bus_req_next  = 1'b1;
        bus_addr_next = issue_pc;
        fetch_pc_next = issue_pc + 32'd4;
      end else begin
        state_next   = IDLE;
        bus_req_next = 1'b0;
      end
    end else if (flush) begin
      // Outstanding request cannot be withdrawn; discard its data on return
      state_next = DROP;
    end
  end

  // Fetch FSM state and bus request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      fetch_pc <= '0;
    end else begin
      state    <= state_next;
      bus_req  <= bus_req_next;
      bus_addr <= bus_addr_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
      count <= count_next;
    end
  end

  // Queue storage write of the returning word tagged with its fetch address
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= bus_addr;
      q_data[tail] <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model of the prefetcher.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef IFQ_BYPASS_EN
  localparam int FILL_LAT = 0;
`else
  localparam int FILL_LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic        inst_pop;
  logic        inst_hit;
  logic [31:0] inst_data;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_pop(inst_pop),
    .inst_hit(inst_hit), .inst_data(inst_data), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch_pc = 0;
  logic [31:0] m_req_addr = 0;
  bit          m_out = 0;
  bit          m_keep = 0;
  bit          m_valid = 0;

  // ---------------- bus slave ----------------
  bit          s_busy = 0;
  int          s_cnt = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] data_q[$];

  // ---------------- per-step observations ----------------
  bit          o_ack, o_hit, o_new_req;
  logic [31:0] o_data, o_new_addr;

  function automatic logic [31:0] model_stream_pc();
    if (mq.size() != 0) return mq[0].addr;
    if (m_out && m_keep) return m_req_addr;
    return m_fetch_pc;
  endfunction

  // One clock cycle: bus slave response, model comparison, model update
  task automatic step();
    bit          hitq, byp, rsy, flsh, exp_hit;
    logic [31:0] exp_data;
    ent_t        e;
    o_new_req = 0;
    if (rst) begin
      bus_ack = 0;
      s_busy = 0;
    end else begin
      if (!s_busy && bus_req) begin
        s_busy = 1;
        s_cnt = $urandom_range(lat_hi, lat_lo);
        o_new_req = 1;
        o_new_addr = bus_addr;
      end
      if (s_busy && s_cnt == 0) begin
        bus_ack = 1;
        s_busy = 0;
        bus_rdata = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
      end else begin
        bus_ack = 0;
        bus_rdata = $urandom;
        if (s_busy) s_cnt--;
      end
    end
    #2;
    hitq = inst_ren && mq.size() != 0 && mq[0].addr == inst_addr;
`ifdef IFQ_BYPASS_EN
    byp = mq.size() == 0 && m_out && m_keep && bus_ack && inst_ren &&
          m_req_addr == inst_addr && !redirect;
`else
    byp = 0;
`endif
    exp_hit = hitq || byp;
    exp_data = hitq ? mq[0].data : (byp ? bus_rdata : 32'd0);
    rsy = inst_ren && !redirect && model_stream_pc() != inst_addr;
    flsh = redirect || rsy;
    o_ack = bus_ack;
    o_hit = inst_hit;
    o_data = inst_data;
    if (m_valid) begin
      checks++;
      if (inst_hit !== exp_hit) begin
        errors++;
        $display("FAIL hit cyc=%0d got=%b exp=%b", cyc, inst_hit, exp_hit);
      end
      checks++;
      if (inst_data !== exp_data) begin
        errors++;
        $display("FAIL data cyc=%0d got=%h exp=%h", cyc, inst_data, exp_data);
      end
      checks++;
      if (bus_req !== m_out) begin
        errors++;
        $display("FAIL bus_req cyc=%0d got=%b exp=%b", cyc, bus_req, m_out);
      end
      if (m_out) begin
        checks++;
        if (bus_addr !== m_req_addr) begin
          errors++;
          $display("FAIL bus_addr cyc=%0d got=%h exp=%h", cyc, bus_addr, m_req_addr);
        end
      end
      checks++;
      if (dut.count !== CW'(mq.size())) begin
        errors++;
        $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, dut.count, mq.size());
      end
    end
    // model update
    if (rst) begin
      mq.delete();
      m_fetch_pc = 0;
      m_req_addr = 0;
      m_out = 0;
      m_keep = 0;
      m_valid = 1;
    end else begin
      if (flsh) begin
        mq.delete();
        m_fetch_pc = redirect ? redirect_addr : inst_addr;
      end else begin
        if (hitq && inst_pop) void'(mq.pop_front());
        if (bus_ack && m_out && m_keep && !(byp && inst_pop)) begin
          e.addr = m_req_addr;
          e.data = bus_rdata;
          mq.push_back(e);
        end
      end
      if (m_out && !bus_ack) begin
        if (flsh) m_keep = 0;
      end else if (mq.size() < DEPTH) begin
        m_out = 1;
        m_keep = 1;
        m_req_addr = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end else begin
        m_out = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    redirect = 0;
    redirect_addr = 0;
    inst_ren = 0;
    inst_addr = 0;
    inst_pop = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    data_q.delete();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    inst_ren = 1;
    inst_addr = 0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus got req=%b addr=%h exp req=0 addr=0", bus_req, bus_addr);
    end
    checks++;
    if (inst_hit !== 1'b0 || inst_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_hit got hit=%b data=%h exp 0/0", inst_hit, inst_data);
    end
    checks++;
    if (dut.count !== CW'(0)) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", dut.count);
    end
    rst = 0;
    inst_ren = 0;
    step();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", bus_req, bus_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req, if_pc;
    int first_ack, first_hit, nhit;
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    data_q.push_back(32'h20080001);
    data_q.push_back(32'h20090002);
    exp_req = 0;
    if_pc = 0;
    first_ack = -1;
    first_hit = -1;
    nhit = 0;
    inst_ren = 1;
    inst_pop = 1;
    for (int i = 0; i < 24; i++) begin
      inst_addr = if_pc;
      step();
      if (o_new_req) begin
        checks++;
        if (o_new_addr !== exp_req) begin
          errors++;
          $display("FAIL stream_addr got=%h exp=%h", o_new_addr, exp_req);
        end
        exp_req = exp_req + 32'd4;
      end
      if (o_ack && first_ack < 0) first_ack = cyc - 1;
      if (o_hit) begin
        if (first_hit < 0) first_hit = cyc - 1;
        if (nhit < 2) begin
          checks++;
          if (o_data !== (nhit == 0 ? 32'h20080001 : 32'h20090002)) begin
            errors++;
            $display("FAIL stream_word%0d got=%h", nhit, o_data);
          end
        end
        if_pc = if_pc + 32'd4;
        nhit++;
      end
    end
    checks++;
    if (first_ack < 0 || first_hit - first_ack != FILL_LAT) begin
      errors++;
      $display("FAIL fill_latency got=%0d exp=%0d", first_hit - first_ack, FILL_LAT);
    end
    checks++;
    if (nhit < 6) begin
      errors++;
      $display("FAIL stream_hits got=%0d exp>=6", nhit);
    end
  endtask

  task automatic test_full();
    int nreq;
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    nreq = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_new_req) nreq++;
    end
    checks++;
    if (nreq != DEPTH || bus_req !== 1'b0 || dut.count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full got reqs=%0d req=%b count=%0d exp %0d/0/%0d",
               nreq, bus_req, dut.count, DEPTH, DEPTH);
    end
    inst_ren = 1;
    inst_addr = 0;
    inst_pop = 1;
    step();
    inst_ren = 0;
    inst_pop = 0;
    checks++;
    if (o_hit !== 1'b1 || bus_req !== 1'b1 || bus_addr !== 32'h10) begin
      errors++;
      $display("FAIL full_reissue got hit=%b req=%b addr=%h exp 1/1/10", o_hit, bus_req, bus_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit found, got_req, got_hit;
    int early_hits;
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus_req === 1'b1 && bus_addr === 32'h8) found = 1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_wait_setup got=timeout exp=req for 8");
    end
    redirect = 1;
    redirect_addr = 32'h40;
    step();
    redirect = 0;
    inst_ren = 1;
    inst_addr = 32'h40;
    got_req = 0;
    early_hits = 0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      step();
      if (o_hit) early_hits++;
      if (o_new_req) begin
        got_req = 1;
        checks++;
        if (o_new_addr !== 32'h40 || dut.count !== CW'(0)) begin
          errors++;
          $display("FAIL redir_wait_next got addr=%h count=%0d exp 40/0", o_new_addr, dut.count);
        end
      end
    end
    checks++;
    if (!got_req || early_hits != 0) begin
      errors++;
      $display("FAIL redir_wait_drop got req=%b hits=%0d exp 1/0", got_req, early_hits);
    end
    got_hit = 0;
    for (int i = 0; i < 10 && !got_hit; i++) begin
      step();
      if (o_hit) got_hit = 1;
    end
    checks++;
    if (!got_hit) begin
      errors++;
      $display("FAIL redir_wait_hit got=0 exp=1");
    end
    inst_ren = 0;
  endtask

  task automatic test_redirect_ack();
    bit found;
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mq.size() >= 1 && s_busy && s_cnt == 0) found = 1;
      else step();
    end
    redirect = 1;
    redirect_addr = 32'h200;
    step();
    redirect = 0;
    checks++;
    if (!found || !o_ack) begin
      errors++;
      $display("FAIL redir_ack_setup got found=%b ack=%b exp 1/1", found, o_ack);
    end
    checks++;
    if (dut.count !== CW'(0) || bus_req !== 1'b1 || bus_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_ack got count=%0d req=%b addr=%h exp 0/1/200", dut.count, bus_req, bus_addr);
    end
    inst_ren = 1;
    inst_addr = 32'h200;
    for (int i = 0; i < 4; i++) step();
    inst_ren = 0;
  endtask

  task automatic test_resync();
    bit got_req, got_hit;
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    for (int i = 0; i < 20 && mq.size() == 0; i++) step();
    inst_ren = 1;
    inst_addr = 32'h100;
    step();
    checks++;
    if (o_hit !== 1'b0 || dut.count !== CW'(0)) begin
      errors++;
      $display("FAIL resync_flush got hit=%b count=%0d exp 0/0", o_hit, dut.count);
    end
    got_req = 0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      step();
      if (o_new_req) begin
        got_req = 1;
        checks++;
        if (o_new_addr !== 32'h100) begin
          errors++;
          $display("FAIL resync_addr got=%h exp=100", o_new_addr);
        end
      end
    end
    got_hit = o_hit;
    for (int i = 0; i < 10 && !got_hit; i++) begin
      step();
      if (o_hit) got_hit = 1;
    end
    checks++;
    if (!got_req || !got_hit) begin
      errors++;
      $display("FAIL resync_hit got req=%b hit=%b exp 1/1", got_req, got_hit);
    end
    inst_ren = 0;
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mq.size() == 3 && m_out) found = 1;
      else step();
    end
    rst = 1;
    inst_ren = 1;
    inst_addr = 0;
    step();
    rst = 0;
    #1;
    checks++;
    if (!found || bus_req !== 1'b0 || dut.count !== CW'(0) || inst_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got found=%b req=%b count=%0d hit=%b exp 1/0/0/0",
               found, bus_req, dut.count, inst_hit);
    end
    inst_ren = 0;
    step();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_restart got req=%b addr=%h exp 1/0", bus_req, bus_addr);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 99);
      rst = (r < 1);
      redirect = (r >= 1 && r < 6);
      if (r == 5) redirect_addr = 32'hFFFF_FFF8;
      else redirect_addr = 32'($urandom_range(0, 63)) << 2;
      inst_ren = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 9) < 8) inst_addr = model_stream_pc();
      else inst_addr = 32'($urandom_range(0, 63)) << 2;
      inst_pop = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1;
    idle_inputs();
    bus_ack = 0;
    bus_rdata = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack();
    test_resync();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch queue sitting directly upstream of the pipelined datapath's IF stage. It fetches sequential instruction words from a variable-latency instruction bus into a small FIFO, tagging each word with its address. The IF stage presents its PC each cycle and gets a same-cycle hit/data answer, and the stall logic holds IF while there is a miss. Branch redirects from the MEM stage flush the queue and restart fetch at the target.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- clk  in  1  main clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  taken branch/jump resolved in MEM (is_branch_mem)
- redirect_addr  in  32  branch target (branch_target_mem)
- inst_ren  in  1  IF stage is requesting an instruction this cycle
- inst_addr  in  32  IF stage PC; word aligned
- inst_pop  in  1  IF stage advances this cycle (if_en)
- inst_hit  out  1  inst_data is valid for inst_addr
- inst_data  out  32  instruction word; 0 when inst_hit=0
- bus_req  out  1  fetch request; registered
- bus_addr  out  32  fetch address; registered, word aligned
- bus_ack  in  1  one-cycle completion strobe for the outstanding request
- bus_rdata  in  32  fetched word; valid while bus_ack=1

## Operation
- Storage: DEPTH entries of {addr[31:0], data[31:0]} with head/tail pointers mod DEPTH and count in 0..DEPTH.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the data will be kept.
  - DROP: request outstanding; the data will be discarded.
- Bus handshake: once bus_req=1, bus_req and bus_addr stay stable until the cycle bus_ack=1. At most one request is outstanding.
- Issue: in IDLE, or in WAIT/DROP on the ack cycle, if the count after this cycle's push/pop is below DEPTH, the block drives bus_req=1 next cycle with bus_addr=fetch_pc. It then advances fetch_pc by 4 and enters WAIT. Otherwise bus_req=0 next cycle and the FSM goes to IDLE.
- Push: bus_ack in WAIT writes {bus_addr, bus_rdata} at the tail. bus_ack in DROP writes nothing.
- Hit: inst_hit = inst_ren && count!=0 && head.addr==inst_addr. Pop occurs when inst_hit && inst_pop.
- stream_pc is the address of the next word the IF stage will receive:
  - head.addr when count!=0;
  - otherwise bus_addr when in WAIT;
  - otherwise fetch_pc.
- Resync: when inst_ren && !redirect && stream_pc!=inst_addr, the block flushes the queue (count←0), sets fetch_pc←inst_addr, and turns WAIT into DROP.
- Redirect: the block flushes the queue, sets fetch_pc←redirect_addr, and turns WAIT into DROP. Redirect has priority over resync, pop and push in the same cycle.
- A new request after a flush issues only once the outstanding request has been acked. Requests are never withdrawn.
- Arithmetic: addresses are 32-bit, and fetch_pc+4 wraps modulo 2^32.

## Timing
- Reset values: bus_req=0, bus_addr=0, inst_hit=0, inst_data=0, count=0, fetch_pc=0, state IDLE.
- A reset during WAIT/DROP abandons the outstanding request. The bus slave shares rst.
- First request: bus_req=1 with bus_addr=0 in the first cycle after rst deasserts.
- Fill latency: an ack in cycle N makes the word hittable in cycle N+1.
- Streaming: the next request issues in cycle N+1, back-to-back with the ack, when the queue has room.
- Full: when count reaches DEPTH, bus_req=0 until the first pop. The request reissues the cycle after that pop.
- Push and pop in the same cycle leave count unchanged.
- Redirect in cycle N:
  - inst_hit=0 in cycle N+1.
  - In IDLE, the target request issues in N+1.
  - In WAIT, the request issues the cycle after the pending ack.

## Configuration
- IFQ_BYPASS_EN defined: when count==0, state WAIT, bus_ack=1, inst_ren=1 and bus_addr==inst_addr, the block forwards the word in the same cycle: inst_hit=1 and inst_data=bus_rdata. If inst_pop is also 1, the word is consumed and not pushed; otherwise it is pushed. Bypass is never taken in DROP or during a redirect.
- IFQ_BYPASS_EN undefined: no forwarding path; the minimum miss-to-hit latency is one cycle after the ack.

## Test plan
- Reset, then acks with 1-cycle latency and data 0x20080001, 0x20090002, and IF pops every hit. Required: bus_addr sequence 0,4,8…; inst_hit for addr 0 one cycle after the first ack (same cycle with IFQ_BYPASS_EN).
- inst_pop=0 held with DEPTH=4. Required: exactly 4 requests, then bus_req=0 and count=4. One pop, then bus_req=1 next cycle with bus_addr=0x10.
- Redirect to 0x40 while a request for 0x8 is in WAIT, ack after 3 cycles. Required: 0x8 data not pushed, inst_hit=0, next bus_addr=0x40.
- Redirect and bus_ack in the same cycle with the queue non-empty. Required: count=0 next cycle, acked word discarded, fetch_pc=redirect_addr.
- inst_addr=0x100 while the head holds 0x0. Required: flush, next request bus_addr=0x100, inst_hit once 0x100 returns.
- rst asserted mid-WAIT with count=3. Required: next cycle bus_req=0, count=0, inst_hit=0. After release, bus_addr=0.
